// File: rtl/simd_mult_acc_pipe.sv
// simd_mult_acc_pipe: three-stage SIMD multiply-accumulate with group framing and output backpressure.
// Ports: clk, reset (async, active-high); in_valid/in_ready beat handshake carrying a, b (2*WIDTH),
// a_sign, b_sign, mode (00/11 full, 01 4x half-width dot, 10 8x quarter-width dot), in_last;
// out_valid/out_ready result handshake with result (ACC_W, signed) and acc_ovf (sticky group overflow).
// Build option: SIMD_MULT_ACC_PIPE_SATURATE_EN clamps the accumulator on overflow instead of wrapping.
module simd_mult_acc_pipe #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 48
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] a,
  input  logic [2*WIDTH-1:0] b,
  input  logic               a_sign,
  input  logic               b_sign,
  input  logic [1:0]         mode,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   result,
  output logic               acc_ovf
);
  localparam int H = WIDTH / 2;
  localparam int Q = WIDTH / 4;
  logic                      w_adv;
  logic                      r_s1_v, r_s1_last, r_s1_as, r_s1_bs;
  logic [1:0]                r_s1_mode;
  logic [2*WIDTH-1:0]        r_s1_a, r_s1_b;
  logic                      r_s2_v, r_s2_last;
  logic signed [ACC_W-1:0]   r_s2_p;
  logic signed [ACC_W-1:0]   r_acc;
  logic                      r_ovf, r_first;
  logic signed [ACC_W-1:0]   w_p0, w_p1, w_p2, w_p, w_sum, w_acc_nxt;
  logic                      w_add_ovf, w_ovf_nxt;
  logic [WIDTH-1:0]          w_fa, w_fb;
  logic [H-1:0]              w_ha, w_hb;
  logic [Q-1:0]              w_qa, w_qb;
  // The whole pipeline advances unless a finished result is waiting on the consumer.
  assign w_adv    = !(out_valid && !out_ready);
  assign in_ready = !reset && w_adv;
  // Each slice is sign- or zero-extended to ACC_W first, so the truncated ACC_W product is exact.
  always_comb begin
    w_fa = r_s1_a[WIDTH-1:0];
    w_fb = r_s1_b[WIDTH-1:0];
    w_p0 = $signed({{(ACC_W-WIDTH){r_s1_as & w_fa[WIDTH-1]}}, w_fa}) *
           $signed({{(ACC_W-WIDTH){r_s1_bs & w_fb[WIDTH-1]}}, w_fb});
    w_p1 = '0;
    w_ha = '0;
    w_hb = '0;
    for (int i = 0; i < 4; i++) begin
      w_ha = r_s1_a[i*H +: H];
      w_hb = r_s1_b[i*H +: H];
      w_p1 = w_p1 + $signed({{(ACC_W-H){r_s1_as & w_ha[H-1]}}, w_ha}) *
                    $signed({{(ACC_W-H){r_s1_bs & w_hb[H-1]}}, w_hb});
    end
    w_p2 = '0;
    w_qa = '0;
    w_qb = '0;
    for (int i = 0; i < 8; i++) begin
      w_qa = r_s1_a[i*Q +: Q];
      w_qb = r_s1_b[i*Q +: Q];
      w_p2 = w_p2 + $signed({{(ACC_W-Q){r_s1_as & w_qa[Q-1]}}, w_qa}) *
                    $signed({{(ACC_W-Q){r_s1_bs & w_qb[Q-1]}}, w_qb});
    end
    w_p = r_s1_mode == 2'b01 ? w_p1 : r_s1_mode == 2'b10 ? w_p2 : w_p0;
  end
  assign w_sum     = r_acc + r_s2_p;
  assign w_add_ovf = (r_acc[ACC_W-1] == r_s2_p[ACC_W-1]) && (w_sum[ACC_W-1] != r_acc[ACC_W-1]);
`ifdef SIMD_MULT_ACC_PIPE_SATURATE_EN
  // An overflowing add always moves away from the accumulator's sign, so clamp toward it.
  assign w_acc_nxt = r_first ? r_s2_p : !w_add_ovf ? w_sum :
                     r_acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`else
  assign w_acc_nxt = r_first ? r_s2_p : w_sum;
`endif
  assign w_ovf_nxt = !r_first && (r_ovf || w_add_ovf);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_v    <= 1'b0;
      r_s1_last <= 1'b0;
      r_s1_as   <= 1'b0;
      r_s1_bs   <= 1'b0;
      r_s1_mode <= 2'b00;
      r_s1_a    <= '0;
      r_s1_b    <= '0;
      r_s2_v    <= 1'b0;
      r_s2_last <= 1'b0;
      r_s2_p    <= '0;
      r_acc     <= '0;
      r_ovf     <= 1'b0;
      r_first   <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      acc_ovf   <= 1'b0;
    end else if (w_adv) begin
      r_s1_v <= in_valid;
      if (in_valid) begin
        r_s1_a    <= a;
        r_s1_b    <= b;
        r_s1_as   <= a_sign;
        r_s1_bs   <= b_sign;
        r_s1_mode <= mode;
        r_s1_last <= in_last;
      end
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_p    <= w_p;
        r_s2_last <= r_s1_last;
      end
      if (r_s2_v) begin
        r_acc   <= w_acc_nxt;
        r_ovf   <= w_ovf_nxt;
        r_first <= r_s2_last;
      end
      out_valid <= r_s2_v && r_s2_last;
      if (r_s2_v && r_s2_last) begin
        result  <= w_acc_nxt;
        acc_ovf <= w_ovf_nxt;
      end
    end
  end
endmodule

// File: tb/tb_simd_mult_acc_pipe.sv
// tb_simd_mult_acc_pipe: directed checks of the SIMD multiply-accumulate pipeline.
module tb_simd_mult_acc_pipe;
  logic        clk = 1'b0, reset = 1'b1;
  logic        in_valid = 1'b0, in_valid2 = 1'b0, out_ready = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic        a_sign = 1'b0, b_sign = 1'b0, in_last = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        in_ready, out_valid, acc_ovf, in_ready2, out_valid2, acc_ovf2;
  logic [47:0] result;
  logic [32:0] result2;
  int          n_chk = 0, n_pass = 0, cyc = 0, n;
  logic [64:0] q1[$], q2[$];
  int          t1[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  simd_mult_acc_pipe #(.WIDTH(16), .ACC_W(48)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .a_sign(a_sign), .b_sign(b_sign), .mode(mode), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .acc_ovf(acc_ovf));
  simd_mult_acc_pipe #(.WIDTH(16), .ACC_W(33)) dut33 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2), .a(a), .b(b),
    .a_sign(a_sign), .b_sign(b_sign), .mode(mode), .in_last(in_last), .out_valid(out_valid2),
    .out_ready(out_ready), .result(result2), .acc_ovf(acc_ovf2));
  always @(negedge clk)
    if (!reset && out_valid && out_ready) begin
      q1.push_back({acc_ovf, 16'h0, result});
      t1.push_back(cyc);
    end
  always @(negedge clk)
    if (!reset && out_valid2 && out_ready) q2.push_back({acc_ovf2, 31'h0, result2});
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask
  task automatic beat(input bit d2, input logic [31:0] ta, input logic [31:0] tb,
                      input logic tas, input logic tbs, input logic [1:0] tm, input logic tl);
    a = ta; b = tb; a_sign = tas; b_sign = tbs; mode = tm; in_last = tl;
    if (d2) in_valid2 = 1'b1;
    else in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_valid2 = 1'b0;
  endtask
  task automatic get(input bit d2, input string tag, input logic [63:0] er, input logic eo);
    logic [64:0] v;
    int k = 0;
    while ((d2 ? q2.size() : q1.size()) == 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if ((d2 ? q2.size() : q1.size()) == 0) begin
      chk({tag, "_timeout"}, 64'(k), 64'd0);
      return;
    end
    v = d2 ? q2.pop_front() : q1.pop_front();
    chk(tag, v[63:0], er);
    chk({tag, "_ovf"}, 64'(v[64]), 64'(eo));
    @(posedge clk); #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_ovf", 64'(acc_ovf), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    beat(1'b0, 32'h0000FFFF, 32'h00000002, 1'b1, 1'b1, 2'b00, 1'b1);
    chk("lat_e0", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_e1", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_e2", 64'(out_valid), 64'd1);
    get(1'b0, "m00_neg", 64'h0000FFFFFFFFFFFE, 1'b0);
    chk("ov_fall", 64'(out_valid), 64'd0);
    beat(1'b0, 32'h04030201, 32'h01010101, 1'b0, 1'b0, 2'b01, 1'b1);
    get(1'b0, "m01_uns", 64'd10, 1'b0);
    beat(1'b0, 32'hFFFFFFFF, 32'h11111111, 1'b1, 1'b1, 2'b10, 1'b1);
    get(1'b0, "m10_sgn", 64'h0000FFFFFFFFFFF8, 1'b0);
    beat(1'b0, 32'h80FF0102, 32'h02030405, 1'b1, 1'b1, 2'b01, 1'b1);
    get(1'b0, "m01_sgn", 64'h0000FFFFFFFFFF0B, 1'b0);
    beat(1'b0, 32'h0000000F, 32'h0000000F, 1'b1, 1'b0, 2'b10, 1'b1);
    get(1'b0, "m10_mixsign", 64'h0000FFFFFFFFFFF1, 1'b0);
    beat(1'b0, 32'h12340003, 32'h56780005, 1'b0, 1'b0, 2'b11, 1'b1);
    get(1'b0, "m11_as_m00", 64'd15, 1'b0);
    beat(1'b0, 32'h00008000, 32'h00008000, 1'b1, 1'b1, 2'b00, 1'b1);
    get(1'b0, "m00_minsq", 64'h40000000, 1'b0);
    beat(1'b0, 32'h0000FFFF, 32'h0000FFFF, 1'b0, 1'b1, 2'b00, 1'b1);
    get(1'b0, "m00_us_x_s", 64'h0000FFFFFFFF0001, 1'b0);
    beat(1'b0, 32'd100, 32'd100, 1'b0, 1'b0, 2'b00, 1'b0);
    beat(1'b0, 32'd100, 32'd100, 1'b0, 1'b0, 2'b00, 1'b0);
    beat(1'b0, 32'd100, 32'd100, 1'b0, 1'b0, 2'b00, 1'b1);
    get(1'b0, "grp3", 64'd30000, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("grp3_one_pulse", 64'(q1.size()), 64'd0);
    beat(1'b0, 32'h04030201, 32'h01010101, 1'b0, 1'b0, 2'b01, 1'b0);
    beat(1'b0, 32'hFFFFFFFF, 32'h11111111, 1'b1, 1'b1, 2'b10, 1'b1);
    get(1'b0, "mixed_mode_grp", 64'd2, 1'b0);
    t1.delete();
    for (int k = 1; k <= 4; k++) beat(1'b0, 32'(k), 32'(k + 1), 1'b0, 1'b0, 2'b00, 1'b1);
    n = 0;
    while (q1.size() < 4 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b_count", 64'(q1.size()), 64'd4);
    if (t1.size() >= 4) chk("b2b_gap", 64'(t1[3] - t1[0]), 64'd3);
    get(1'b0, "b2b_0", 64'd2, 1'b0);
    get(1'b0, "b2b_1", 64'd6, 1'b0);
    get(1'b0, "b2b_2", 64'd12, 1'b0);
    get(1'b0, "b2b_3", 64'd20, 1'b0);
    out_ready = 1'b0;
    beat(1'b0, 32'd7, 32'd6, 1'b0, 1'b0, 2'b00, 1'b1);
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("stall_ov", 64'(out_valid), 64'd1);
    a = 32'd3; b = 32'd3; a_sign = 1'b0; b_sign = 1'b0; mode = 2'b00; in_last = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_result", 64'(result), 64'd42);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    get(1'b0, "stall_g1", 64'd42, 1'b0);
    get(1'b0, "stall_g2", 64'd9, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("stall_nodup", 64'(q1.size()), 64'd0);
    out_ready = 1'b0;
    beat(1'b0, 32'd100, 32'd100, 1'b0, 1'b0, 2'b00, 1'b0);
    beat(1'b0, 32'd7, 32'd6, 1'b0, 1'b0, 2'b00, 1'b1);
    beat(1'b0, 32'd9, 32'd9, 1'b0, 1'b0, 2'b00, 1'b0);
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("pre_rst_result", 64'(result), 64'd10042);
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_result", 64'(result), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    beat(1'b0, 32'd5, 32'd5, 1'b0, 1'b0, 2'b00, 1'b1);
    get(1'b0, "post_rst_load", 64'd25, 1'b0);
    for (int k = 0; k < 5; k++)
      beat(1'b1, 32'h00007FFF, 32'h00007FFF, 1'b1, 1'b1, 2'b00, k == 4);
`ifdef SIMD_MULT_ACC_PIPE_SATURATE_EN
    get(1'b1, "acc33_ovf", 64'h0FFFFFFFF, 1'b1);
`else
    get(1'b1, "acc33_ovf", 64'h13FFB0005, 1'b1);
`endif
    beat(1'b1, 32'd1, 32'd1, 1'b1, 1'b1, 2'b00, 1'b1);
    get(1'b1, "acc33_ovf_clear", 64'd1, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
